ctrl_var_bank: RTL and testbench

//  Parametrised bank of NUM_VARS debug control variables, each WIDTH bits, edited from four debounced buttons.

---
 rtl/ctrl_var_pkg.sv | 16 +
 rtl/ctrl_var_bank_tick_prescaler.sv | 29 ++
 rtl/ctrl_var_bank.sv | 155 +++++++++++++++
 tb/tb_ctrl_var_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_var_pkg.sv
// rtl/ctrl_var_pkg.sv - shared FSM and direction types for the control-variable bank
package ctrl_var_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SLOW = 2'd2,
        FAST = 2'd3
    } hold_fsm_t;

    typedef enum logic {
        DN = 1'b0,
        UP = 1'b1
    } step_dir_t;

endpackage

// File: rtl/ctrl_var_bank_tick_prescaler.sv
// rtl/ctrl_var_bank_tick_prescaler.sv - free-running repeat-tick divider, restarted by clear
module tick_prescaler #(
    parameter int TICK_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + PW'(1);
        end
    end

    // count is held at zero while cleared, so no tick can leak out of IDLE
    assign tick = (count == LAST);

endmodule

// File: rtl/ctrl_var_bank.sv
// rtl/ctrl_var_bank.sv - button-edited bank of debug variables with press-and-hold acceleration
// Optional: CTRL_VAR_SAT_EN selects saturating steps instead of wrap-around.
module ctrl_var_bank
    import ctrl_var_pkg::*;
#(
    parameter int NUM_VARS    = 16,
    parameter int WIDTH       = 16,
    parameter logic [NUM_VARS-1:0][WIDTH-1:0] INIT = '0,
    parameter int TICK_CYCLES = 10,
    parameter int HOLD_TICKS  = 10,
    parameter int FAST_TICKS  = 20,
    parameter int STEP_SLOW   = 1,
    parameter int STEP_FAST   = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               btn_inc,
    input  logic                               btn_dec,
    input  logic                               btn_next,
    input  logic                               btn_prev,
    output logic [NUM_VARS-1:0][WIDTH-1:0]     control_vars,
    output logic [$clog2(NUM_VARS)-1:0]        sel_idx,
    output logic                               var_changed,
    output hold_fsm_t                          hold_state
);

    localparam int IW   = $clog2(NUM_VARS);
    localparam int MAXT = (HOLD_TICKS > FAST_TICKS) ? HOLD_TICKS : FAST_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_VARS - 1);
    localparam logic [WIDTH-1:0] STEP_S   = WIDTH'(STEP_SLOW);
    localparam logic [WIDTH-1:0] STEP_F   = WIDTH'(STEP_FAST);

    logic            next_q, prev_q;
    logic            next_rise, prev_rise;
    logic            tick, held;
    logic [CW-1:0]   tick_cnt;
    step_dir_t       dir;
    logic            do_step, step_up, changed;
    logic [WIDTH-1:0] step_amt, cur, stepped;

    tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (hold_state == IDLE),
        .tick  (tick)
    );

    assign next_rise = btn_next && !next_q;
    assign prev_rise = btn_prev && !prev_q;
    assign held      = (dir == UP) ? btn_inc : btn_dec;
    assign cur       = control_vars[sel_idx];

    always_comb begin
        do_step  = 1'b0;
        step_up  = (dir == UP);
        step_amt = STEP_S;
        case (hold_state)
            IDLE: begin
                do_step = btn_inc ^ btn_dec;
                step_up = btn_inc;
            end
            SLOW: do_step = held && tick;
            FAST: begin
                do_step  = held && tick;
                step_amt = STEP_F;
            end
            default: ;
        endcase
    end

`ifdef CTRL_VAR_SAT_EN
    logic [WIDTH:0] sum, diff;

    always_comb begin
        sum  = {1'b0, cur} + {1'b0, step_amt};
        diff = {1'b0, cur} - {1'b0, step_amt};
        if (step_up) begin
            stepped = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end else begin
            stepped = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
        end
        changed = (stepped != cur);
    end
`else
    assign stepped = step_up ? cur + step_amt : cur - step_amt;
    assign changed = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            control_vars <= INIT;
            sel_idx      <= '0;
            var_changed  <= 1'b0;
            hold_state   <= IDLE;
            tick_cnt     <= '0;
            dir          <= UP;
            next_q       <= 1'b0;
            prev_q       <= 1'b0;
        end else begin
            next_q      <= btn_next;
            prev_q      <= btn_prev;
            var_changed <= 1'b0;
            if (do_step) begin
                control_vars[sel_idx] <= stepped;
                var_changed           <= changed;
            end
            case (hold_state)
                IDLE: begin
                    if (next_rise && !prev_rise) begin
                        sel_idx <= (sel_idx == LAST_IDX) ? '0 : sel_idx + IW'(1);
                    end else if (prev_rise && !next_rise) begin
                        sel_idx <= (sel_idx == '0) ? LAST_IDX : sel_idx - IW'(1);
                    end
                    if (btn_inc ^ btn_dec) begin
                        hold_state <= HOLD;
                        dir        <= btn_inc ? UP : DN;
                        tick_cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (!held) begin
                        hold_state <= IDLE;
                    end else if (tick) begin
                        if (tick_cnt == CW'(HOLD_TICKS - 1)) begin
                            hold_state <= SLOW;
                            tick_cnt   <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                end
                SLOW: begin
                    if (!held) begin
                        hold_state <= IDLE;
                    end else if (tick) begin
                        if (tick_cnt == CW'(FAST_TICKS - 1)) begin
                            hold_state <= FAST;
                            tick_cnt   <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                end
                FAST: begin
                    if (!held) begin
                        hold_state <= IDLE;
                    end
                end
                default: hold_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_var_bank.sv
// tb/tb_ctrl_var_bank.sv - scoreboard bench for ctrl_var_bank with a hold-duration reference model
module tb_ctrl_var_bank;
    import ctrl_var_pkg::*;

    localparam int NV = 4;
    localparam int W  = 8;
    localparam int TC = 4;
    localparam int HT = 2;
    localparam int FT = 3;
    localparam int SS = 1;
    localparam int SF = 10;
    localparam logic [NV-1:0][W-1:0] INIT_V = {8'd250, 8'd0, 8'd0, 8'd0};

    typedef struct {
        int idx;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic reset, btn_inc, btn_dec, btn_next, btn_prev;
    logic [NV-1:0][W-1:0] control_vars;
    logic [1:0] sel_idx;
    logic var_changed;
    hold_fsm_t hold_state;

    exp_t exp_q[$];
    int   vals_m[NV];
    int   sel_m;
    int   shadow[NV];
    int   checks = 0;
    int   passes = 0;

    ctrl_var_bank #(
        .NUM_VARS(NV), .WIDTH(W), .INIT(INIT_V), .TICK_CYCLES(TC),
        .HOLD_TICKS(HT), .FAST_TICKS(FT), .STEP_SLOW(SS), .STEP_FAST(SF)
    ) dut (
        .clk(clk), .reset(reset), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_next(btn_next), .btn_prev(btn_prev), .control_vars(control_vars),
        .sel_idx(sel_idx), .var_changed(var_changed), .hold_state(hold_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int mstep(input int v, input int amt, input bit up);
        int r;
        r = up ? v + amt : v - amt;
`ifdef CTRL_VAR_SAT_EN
        if (r > 255) r = 255;
        if (r < 0) r = 0;
`else
        r = r & 255;
`endif
        return r;
    endfunction

    // Expected step for one update; a saturated no-op produces no pulse
    task automatic apply(input int s, input int amt, input bit up);
        int nv;
        exp_t e;
        nv = mstep(vals_m[s], amt, up);
`ifdef CTRL_VAR_SAT_EN
        if (nv != vals_m[s]) begin
            e.idx = s; e.val = nv; exp_q.push_back(e);
        end
`else
        e.idx = s; e.val = nv; exp_q.push_back(e);
`endif
        vals_m[s] = nv;
    endtask

    // A press held for d cycles: one immediate step, then tick k at TC*k cycles
    task automatic push_hold(input int s, input bit up, input int d);
        int n;
        n = (d - 1) / TC;
        apply(s, SS, up);
        for (int k = 1; k <= n; k++) begin
            if (k > HT) apply(s, (k <= HT + FT) ? SS : SF, up);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < NV; i++) shadow[i] = int'(INIT_V[i]);
        end else if (var_changed) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_var_changed", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("step_value", int'(control_vars[e.idx]), e.val);
                for (int i = 0; i < NV; i++) begin
                    if (i != e.idx) chk("other_var_held", int'(control_vars[i]), shadow[i]);
                end
                shadow[e.idx] = e.val;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sel(input bit nx, input bit pv);
        btn_next = nx; btn_prev = pv;
        cycle();
        btn_next = 0; btn_prev = 0;
        cycle();
        if (nx && !pv) sel_m = (sel_m + 1) % NV;
        else if (pv && !nx) sel_m = (sel_m + NV - 1) % NV;
        chk("sel_idx", int'(sel_idx), sel_m);
    endtask

    task automatic goto_sel(input int t);
        for (int g = 0; g < NV && sel_m != t; g++) pulse_sel(1, 0);
    endtask

    task automatic do_hold(input bit up, input int d, input bit poke_next, input bit other);
        int lo;
        lo = (d / 3 < 1) ? 1 : d / 3;
        push_hold(sel_m, up, d);
        if (up) btn_inc = 1; else btn_dec = 1;
        for (int c = 0; c < d; c++) begin
            if (other) begin
                if (up) btn_dec = (c >= lo && c < d / 2);
                else btn_inc = (c >= lo && c < d / 2);
            end
            if (poke_next) btn_next = (c == 2);
            cycle();
            if (c == 0) chk("hold_entered", int'(hold_state), int'(HOLD));
        end
        btn_inc = 0; btn_dec = 0; btn_next = 0;
        cycle();
        chk("release_idle", int'(hold_state), int'(IDLE));
        repeat (2) cycle();
        if (poke_next) chk("sel_locked_in_hold", int'(sel_idx), sel_m);
    endtask

    initial begin
        reset = 1; btn_inc = 0; btn_dec = 0; btn_next = 0; btn_prev = 0;
        for (int i = 0; i < NV; i++) vals_m[i] = int'(INIT_V[i]);
        sel_m = 0;
        repeat (3) cycle();
        chk("rst_sel", int'(sel_idx), 0);
        chk("rst_state", int'(hold_state), int'(IDLE));
        chk("rst_changed", int'(var_changed), 0);
        for (int i = 0; i < NV; i++) chk("rst_var", int'(control_vars[i]), vals_m[i]);
        reset = 0;
        cycle();

        pulse_sel(0, 1);
        pulse_sel(1, 0);
        pulse_sel(1, 1);

        do_hold(1, 1, 0, 0);
        chk("single_press_var0", int'(control_vars[0]), vals_m[0]);

        goto_sel(1);
        do_hold(0, 40, 0, 0);
        chk("dec_fast_var1", int'(control_vars[1]), vals_m[1]);

        goto_sel(3);
        do_hold(1, 30, 0, 0);
        chk("inc_fast_var3", int'(control_vars[3]), vals_m[3]);

        goto_sel(2);
        do_hold(1, 14, 1, 0);
        btn_inc = 1; btn_dec = 1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("both_high_idle", int'(hold_state), int'(IDLE));
        end
        btn_inc = 0; btn_dec = 0;
        cycle();

        for (int it = 0; it < 12; it++) begin
            int moves;
            moves = $urandom_range(0, 3);
            for (int m = 0; m < moves; m++) begin
                int kind;
                kind = $urandom_range(0, 2);
                pulse_sel(kind != 1, kind != 0);
            end
            do_hold($urandom_range(0, 1) == 1, $urandom_range(1, 45), 0, 1);
        end

        goto_sel(0);
        push_hold(0, 1, 27);
        btn_inc = 1;
        repeat (27) cycle();
        chk("pre_reset_fast", int'(hold_state), int'(FAST));
        reset = 1;
        cycle();
        chk("midhold_rst_state", int'(hold_state), int'(IDLE));
        chk("midhold_rst_sel", int'(sel_idx), 0);
        chk("midhold_rst_changed", int'(var_changed), 0);
        for (int i = 0; i < NV; i++) begin
            vals_m[i] = int'(INIT_V[i]);
            chk("midhold_rst_var", int'(control_vars[i]), vals_m[i]);
        end
        sel_m = 0;
        reset = 0;
        apply(0, SS, 1);
        cycle();
        chk("reenter_hold", int'(hold_state), int'(HOLD));
        chk("reenter_var0", int'(control_vars[0]), vals_m[0]);
        btn_inc = 0;
        repeat (3) cycle();

        chk("queue_drained", exp_q.size(), 0);
        for (int i = 0; i < NV; i++) chk("final_var", int'(control_vars[i]), vals_m[i]);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
